matrix_scroll_ctrl: RTL and testbench

MATRIX_SCROLL_CTRL -- requirements
Module: matrix_scroll_ctrl

---
 rtl/matrix_scroll_ctrl_if.sv | 22 ++
 rtl/matrix_scroll_ctrl.sv | 131 +++++++++++++
 tb/tb_matrix_scroll_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scroll_ctrl_if.sv
// Control and display bus of the 8x8 bicolour scrolling-digit matrix driver.
// The master drives the run controls, and the slave (the controller) drives the row and column lines.
interface matrix_scroll_ctrl_if;
    logic       en;
    logic       dir;
    logic       hold;
    logic [1:0] sel;
    logic [7:0] row;
    logic [7:0] column_green;
    logic [7:0] column_red;
    logic       step_pulse;

    modport master (
        output en, dir, hold, sel,
        input  row, column_green, column_red, step_pulse
    );

    modport slave (
        input  en, dir, hold, sel,
        output row, column_green, column_red, step_pulse
    );
endinterface

// File: rtl/matrix_scroll_ctrl.sv
// Row-scanning, vertically scrolling digit display driver for an 8x8 bicolour LED matrix.
// Optional blink-while-paused is enabled by defining MATRIX_SCROLL_BLINK_EN.
module matrix_scroll_ctrl #(
    parameter int SCAN_DIV    = 4096,
    parameter int STEP_FRAMES = 512,
    parameter int NUM_CHARS   = 10
) (
    input  logic                clk,
    input  logic                rst,
    matrix_scroll_ctrl_if.slave bus
);
    localparam int               DIV_W      = $clog2(SCAN_DIV);
    localparam int               FC_W       = $clog2(STEP_FRAMES + 1);
    localparam int               FONT_BYTES = 8 * (NUM_CHARS + 1);
    localparam logic [6:0]       OMAX       = 7'(8 * NUM_CHARS);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0]  FC_TOP     = FC_W'(STEP_FRAMES);

    // NOTE: the font is a constant table decoded from the address, so it holds no state and needs no reset.
    function automatic logic [7:0] font_byte(input logic [6:0] addr);
        logic [63:0] glyph;
        glyph = '0;
        case (addr[6:3])
            4'd1:    glyph = 64'h3C42464A52623C00;
            4'd2:    glyph = 64'h0818280808083E00;
            4'd3:    glyph = 64'h3C42020C30407E00;
            4'd4:    glyph = 64'h3C42021C02423C00;
            4'd5:    glyph = 64'h040C14247E040400;
            4'd6:    glyph = 64'h7E407C0202423C00;
            4'd7:    glyph = 64'h1C20407C42423C00;
            4'd8:    glyph = 64'h7E02040810101000;
            4'd9:    glyph = 64'h3C42423C42423C00;
            4'd10:   glyph = 64'h3C42423E02043800;
            default: glyph = '0;
        endcase
        if (int'(addr) >= FONT_BYTES)
            return 8'h00;
        return glyph[8 * (7 - int'(addr[2:0])) +: 8];
    endfunction

    logic [DIV_W-1:0] div_q;
    logic [2:0]       cnt_q;
    logic [7:0]       row_q;
    logic [7:0]       col_g_q;
    logic [7:0]       col_r_q;
    logic [6:0]       offset_q;
    logic [FC_W-1:0]  frame_q;
    logic             step_q;

    logic             tick;
    logic             wrap;
    logic             step_due;
    logic             blank;
    logic [2:0]       cnt_next;
    logic [FC_W-1:0]  frame_inc;
    logic [FC_W-1:0]  frame_next;
    logic [6:0]       offset_step;
    logic [6:0]       offset_next;
    logic [7:0]       glyph;

    // NOTE: each always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        tick        = bus.en && (div_q == DIV_LAST);
        cnt_next    = cnt_q + 3'd1;
        wrap        = (cnt_q == 3'd7);
        frame_inc   = (frame_q == FC_TOP) ? frame_q : frame_q + 1'b1;
        step_due    = wrap && (frame_inc == FC_TOP) && !bus.hold;
        offset_step = offset_q;
        if (bus.dir)
            offset_step = (offset_q == OMAX) ? 7'd0 : offset_q + 7'd1;
        else
            offset_step = (offset_q == 7'd0) ? OMAX : offset_q - 7'd1;
        offset_next = step_due ? offset_step : offset_q;
        frame_next  = step_due ? '0 : (wrap ? frame_inc : frame_q);
        // Row 0 of a new frame already shows the stepped offset, so every frame is drawn from a single offset.
        glyph       = font_byte(offset_next + {4'd0, cnt_next});
    end

`ifdef MATRIX_SCROLL_BLINK_EN
    logic [5:0] blink_q;
    logic [5:0] blink_next;

    always_comb begin
        blink_next = wrap ? blink_q + 6'd1 : blink_q;
        blank      = bus.hold && blink_next[5];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blink_q <= '0;
        else if (!bus.hold)
            blink_q <= '0;
        else if (tick)
            blink_q <= blink_next;
    end
`else
    assign blank = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments, so every flop samples its pre-edge inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            cnt_q    <= 3'd0;
            row_q    <= 8'b0000_0001;
            offset_q <= OMAX;
            frame_q  <= '0;
            col_g_q  <= 8'h00;
            col_r_q  <= 8'h00;
            step_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (bus.en)
                div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                row_q    <= {row_q[0], row_q[7:1]};
                cnt_q    <= cnt_next;
                offset_q <= offset_next;
                frame_q  <= frame_next;
                col_g_q  <= (bus.sel[0] && !blank) ? glyph : 8'h00;
                col_r_q  <= (bus.sel[1] && !blank) ? glyph : 8'h00;
                step_q   <= step_due;
            end
        end
    end

    assign bus.row          = row_q;
    assign bus.column_green = col_g_q;
    assign bus.column_red   = col_r_q;
    assign bus.step_pulse   = step_q;
endmodule

// File: tb/tb_matrix_scroll_ctrl.sv
// Bench for matrix_scroll_ctrl: a frame/offset model is checked against the DUT every cycle.
// Directed literal checks cover reset, first tick, offset wrap, hold, colour select and freeze.
module tb_matrix_scroll_ctrl;
    localparam int SCAN_DIV    = 2;
    localparam int STEP_FRAMES = 1;
    localparam int NUM_CHARS   = 10;
    localparam int OMAX        = 8 * NUM_CHARS;
    localparam int STEP_CYC    = SCAN_DIV * 8 * STEP_FRAMES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    matrix_scroll_ctrl_if bus();

    matrix_scroll_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .STEP_FRAMES(STEP_FRAMES),
        .NUM_CHARS  (NUM_CHARS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Font: blank character, then digits 0..9, with each glyph stored top row first.
    logic [63:0] glyphs [10] = '{
        64'h3C42464A52623C00, 64'h0818280808083E00, 64'h3C42020C30407E00,
        64'h3C42021C02423C00, 64'h040C14247E040400, 64'h7E407C0202423C00,
        64'h1C20407C42423C00, 64'h7E02040810101000, 64'h3C42423C42423C00,
        64'h3C42423E02043800};
    logic [7:0] font [0:127];

    initial begin
        for (int a = 0; a < 128; a++)
            font[a] = 8'h00;
        for (int d = 0; d < NUM_CHARS; d++)
            for (int r = 0; r < 8; r++)
                font[8 + 8 * d + r] = glyphs[d][8 * (7 - r) +: 8];
    end

    // The model counts enabled cycles, ticks and frames, and derives the outputs from those counts.
    int         m_en_cycles = 0;
    int         m_ticks     = 0;
    int         m_offset    = OMAX;
    int         m_frames    = 0;
    int         m_blink     = 0;
    logic       m_step      = 1'b0;
    logic [7:0] m_g         = 8'h00;
    logic [7:0] m_r         = 8'h00;
    int         m_hist [$];

    always @(posedge clk or posedge rst) begin
        int         line;
        bit         blank;
        logic [7:0] g;
        if (rst) begin
            m_en_cycles = 0;
            m_ticks     = 0;
            m_offset    = OMAX;
            m_frames    = 0;
            m_blink     = 0;
            m_step      = 1'b0;
            m_g         = 8'h00;
            m_r         = 8'h00;
        end else begin
            m_step = 1'b0;
            if (!bus.hold)
                m_blink = 0;
            if (bus.en) begin
                m_en_cycles++;
                if (m_en_cycles % SCAN_DIV == 0) begin
                    m_ticks++;
                    line = m_ticks % 8;
                    if (line == 0) begin
                        if (m_frames < STEP_FRAMES)
                            m_frames++;
                        if (bus.hold)
                            m_blink++;
                        if (m_frames == STEP_FRAMES && !bus.hold) begin
                            m_offset = bus.dir ? (m_offset + 1) % (OMAX + 1)
                                               : (m_offset + OMAX) % (OMAX + 1);
                            m_frames = 0;
                            m_step   = 1'b1;
                            m_hist.push_back(m_offset);
                        end
                    end
`ifdef MATRIX_SCROLL_BLINK_EN
                    blank = bus.hold && ((m_blink / 32) % 2 == 1);
`else
                    blank = 1'b0;
`endif
                    g   = font[m_offset + line];
                    m_g = (bus.sel[0] && !blank) ? g : 8'h00;
                    m_r = (bus.sel[1] && !blank) ? g : 8'h00;
                end
            end
        end
    end

    function automatic logic [7:0] exp_row(input int t);
        int line;
        line = t % 8;
        return (line == 0) ? 8'h01 : 8'h80 >> (line - 1);
    endfunction

    always @(posedge clk) begin
        #1;
        check("scan", {bus.row, bus.column_green, bus.column_red, 7'd0, bus.step_pulse},
              {exp_row(m_ticks), m_g, m_r, 7'd0, m_step});
    end

    int dut_steps = 0;
    always @(posedge clk) begin
        #1;
        if (bus.step_pulse === 1'b1)
            dut_steps++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         s0;
        int         h0;
        int         bad;
        int         wraps;
        int         prev;
        logic [7:0] r0;
        logic [7:0] g0;
        logic [7:0] c0;

        bus.en   = 1'b0;
        bus.dir  = 1'b0;
        bus.hold = 1'b0;
        bus.sel  = 2'b11;
        rst      = 1'b1;
        cycles(3);
        check("reset_row", bus.row, 8'h01);
        check("reset_cols", {bus.column_green, bus.column_red}, 16'h0000);
        check("reset_step", bus.step_pulse, 1'b0);

        bus.en = 1'b1;
        rst    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("first_tick_row", bus.row, 8'h80);
        check("first_tick_green", bus.column_green, 8'h42);
        check("first_tick_red", bus.column_red, 8'h42);
        check("model_first_tick", m_g, 8'h42);

        repeat (14) @(posedge clk);
        #1;
        check("first_step_pulse", bus.step_pulse, 1'b1);
        check("model_first_step_offset", m_offset, 79);
        @(negedge clk);

        // Top-to-bottom: a full cycle of 81 offsets, wrapping 0 -> OMAX exactly once.
        h0 = m_hist.size();
        s0 = dut_steps;
        cycles(81 * STEP_CYC);
        check("down_step_count", dut_steps - s0, 81);
        check("model_down_steps", m_hist.size() - h0, 81);
        bad   = 0;
        wraps = 0;
        for (int i = h0; i < m_hist.size(); i++) begin
            prev = m_hist[i - 1];
            if (prev == 0) begin
                wraps++;
                if (m_hist[i] != OMAX) bad++;
            end else if (m_hist[i] != prev - 1) begin
                bad++;
            end
        end
        check("model_down_sequence", bad, 0);
        check("model_down_wrap_once", wraps, 1);
        check("model_down_return", m_hist[m_hist.size() - 1], m_hist[h0 - 1]);

        // Bottom-to-top, with dir changed mid-frame.
        cycles(5);
        bus.dir = 1'b1;
        h0 = m_hist.size();
        s0 = dut_steps;
        cycles(81 * STEP_CYC);
        check("up_step_count", dut_steps - s0, 81);
        bad   = 0;
        wraps = 0;
        for (int i = h0; i < m_hist.size(); i++) begin
            prev = m_hist[i - 1];
            if (prev == OMAX) begin
                wraps++;
                if (m_hist[i] != 0) bad++;
            end else if (m_hist[i] != prev + 1) begin
                bad++;
            end
        end
        check("model_up_sequence", bad, 0);
        check("model_up_wrap_once", wraps, 1);

        // Hold pauses the scroll for five frames, and then exactly one step follows release.
        bus.hold = 1'b1;
        s0 = dut_steps;
        h0 = m_offset;
        cycles(5 * STEP_CYC);
        check("hold_no_step", dut_steps - s0, 0);
        check("model_hold_offset", m_offset, h0);
        bus.hold = 1'b0;
        s0 = dut_steps;
        cycles(STEP_CYC);
        check("hold_release_one_step", dut_steps - s0, 1);

        // Colour select takes effect from the next tick onwards.
        bus.sel = 2'b01;
        cycles(SCAN_DIV);
        bad = 0;
        repeat (STEP_CYC) begin
            @(negedge clk);
            if (bus.column_red !== 8'h00) bad++;
        end
        check("sel01_red_off", bad, 0);
        bus.sel = 2'b00;
        cycles(SCAN_DIV);
        bad = 0;
        repeat (STEP_CYC) begin
            @(negedge clk);
            if (bus.column_red !== 8'h00 || bus.column_green !== 8'h00) bad++;
        end
        check("sel00_dark", bad, 0);

        // Enable low freezes the row, columns and scroll.
        bus.sel = 2'b11;
        cycles(5);
        r0 = bus.row;
        g0 = bus.column_green;
        c0 = bus.column_red;
        bus.en = 1'b0;
        s0 = dut_steps;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.row !== r0 || bus.column_green !== g0 || bus.column_red !== c0) bad++;
        end
        check("en_freeze", bad, 0);
        check("en_freeze_no_step", dut_steps - s0, 0);
        bus.en = 1'b1;
        cycles(3 * STEP_CYC + 3);

        // Asynchronous reset mid-scroll, followed by a restart from the reset state.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_row", bus.row, 8'h01);
        check("async_reset_cols", {bus.column_green, bus.column_red}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("restart_row", bus.row, 8'h80);
        check("restart_green", bus.column_green, 8'h42);
        @(negedge clk);

`ifdef MATRIX_SCROLL_BLINK_EN
        bus.hold = 1'b1;
        cycles(40 * STEP_CYC);
        bad = 0;
        repeat (STEP_CYC) begin
            @(negedge clk);
            if (bus.column_red !== 8'h00 || bus.column_green !== 8'h00) bad++;
        end
        check("blink_dark_phase", bad, 0);
        bus.hold = 1'b0;
        cycles(STEP_CYC);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
